lsu_ctrl: RTL and testbench

//  Memory-stage load/store initiator: turns a MEM-stage access into byte-lane

---
 rtl/lsu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store initiator: issues one or two aligned word beats per access
// on a ready-handshaked port, stalls the pipeline, and returns extended load data.
//
// state | meaning
// IDLE  | no access in flight; stall follows the incoming request
// BEAT0 | first (or only) word beat presented, waiting for mem_ready
// BEAT1 | second word beat of a misaligned access, waiting for mem_ready
// RESP  | access done, readdataM valid, pipeline advances
module lsu_ctrl #(
    parameter int AW = 18,
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] aluresultM,
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [2:0]    memctrlM,
    input  logic [WD-1:0] writedataM,
    output logic [WD-1:0] readdataM,
    output logic          stallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [WD-1:0] mem_wdata,
    input  logic [WD-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t        state;
    logic [1:0]    lane_q;
    logic [2:0]    ctrl_q;
    logic [3:0]    be1_q;
    logic [WD-1:0] rdata_acc;

    logic [3:0]    size_mask;
    logic [7:0]    be_span;
    logic [WD-1:0] rd_merge;
    logic [WD-1:0] load_result;

    function automatic logic [WD-1:0] rotl_bytes(input logic [WD-1:0] d, input logic [1:0] a);
        logic [WD-1:0] r;
        case (a)
            2'd0:    r = d;
            2'd1:    r = {d[23:0], d[31:24]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[7:0],  d[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [WD-1:0] rotr_bytes(input logic [WD-1:0] d, input logic [1:0] a);
        logic [WD-1:0] r;
        case (a)
            2'd0:    r = d;
            2'd1:    r = {d[7:0],  d[31:8]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[23:0], d[31:24]};
        endcase
        return r;
    endfunction

    function automatic logic [WD-1:0] extend(input logic [WD-1:0] raw, input logic [2:0] ctrl);
        logic [WD-1:0] r;
        if (ctrl[1])
            r = raw;
        else if (ctrl[0])
            r = ctrl[2] ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        else
            r = ctrl[2] ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
        return r;
    endfunction

    // Lanes spilling past lane 3 (upper nibble of be_span) belong to the second beat.
    always_comb begin
        size_mask = 4'b0001;
        if (memctrlM[1])
            size_mask = 4'b1111;
        else if (memctrlM[0])
            size_mask = 4'b0011;
        be_span = {4'b0000, size_mask} << aluresultM[1:0];
    end

    always_comb begin
        rd_merge = rdata_acc;
        for (int i = 0; i < 4; i++) begin
            if (mem_be[i])
                rd_merge[8*i +: 8] = mem_rdata[8*i +: 8];
        end
        load_result = extend(rotr_bytes(rd_merge, lane_q), ctrl_q);
    end

    always_comb begin
        stallM = 1'b0;
        case (state)
            IDLE:         stallM = rst_n & (memreadM | memwriteM);
            BEAT0, BEAT1: stallM = 1'b1;
            default:      stallM = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane_q    <= 2'b00;
            ctrl_q    <= 3'b000;
            be1_q     <= 4'b0000;
            rdata_acc <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            readdataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memreadM | memwriteM) begin
                        lane_q    <= aluresultM[1:0];
                        ctrl_q    <= memctrlM;
                        be1_q     <= be_span[7:4];
                        rdata_acc <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= memwriteM;
                        mem_addr  <= {aluresultM[AW-1:2], 2'b00};
                        mem_be    <= be_span[3:0];
                        mem_wdata <= rotl_bytes(writedataM, aluresultM[1:0]);
                        state     <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (be1_q != 4'b0000) begin
                            rdata_acc <= rd_merge;
                            mem_addr  <= mem_addr + AW'(4);
                            mem_be    <= be1_q;
                            state     <= BEAT1;
                        end else begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            mem_be  <= 4'b0000;
                            if (!mem_we)
                                readdataM <= load_result;
                            state   <= RESP;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        if (!mem_we)
                            readdataM <= load_result;
                        state   <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random accesses checked against a byte-address
// model of which word/lane each access byte lands in.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic [17:0] aluresultM;
    logic        memreadM;
    logic        memwriteM;
    logic [2:0]  memctrlM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          vectors;
    int          miscompares;
    logic [31:0] last_load;

    lsu_ctrl #(.AW(18), .WD(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aluresultM (aluresultM),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .memctrlM   (memctrlM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Walks the access byte by byte: byte k sits at byte address addr+k (mod 2^18),
    // which picks its word (beat) and its lane.
    task automatic access(input bit we, input logic [2:0] ctrl, input logic [17:0] addr,
                          input logic [31:0] data, input logic [31:0] rd0,
                          input logic [31:0] rd1, input int max_wait);
        int          nbytes;
        int          nbeats;
        int          b;
        int          ln;
        int          wcycles;
        logic [17:0] ba;
        logic [17:0] wa   [2];
        logic [3:0]  be   [2];
        logic [31:0] wexp [2];
        logic [31:0] rd   [2];
        logic [31:0] raw;
        logic [31:0] expv;

        nbytes = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
        rd[0] = rd0;
        rd[1] = rd1;
        be[0] = 4'b0000;
        be[1] = 4'b0000;
        wexp[0] = 32'h0;
        wexp[1] = 32'h0;
        raw = 32'h0;
        nbeats = 1;
        wa[0] = {addr[17:2], 2'b00};
        wa[1] = wa[0] + 18'd4;
        for (int k = 0; k < nbytes; k++) begin
            ba = addr + 18'(k);
            ln = int'(ba[1:0]);
            b = ({ba[17:2], 2'b00} == wa[0]) ? 0 : 1;
            if (b == 1) nbeats = 2;
            be[b][ln] = 1'b1;
            wexp[b][8*ln +: 8] = data[8*k +: 8];
            raw[8*k +: 8] = rd[b][8*ln +: 8];
        end
        case (ctrl)
            3'b000:  expv = {{24{raw[7]}}, raw[7:0]};
            3'b001:  expv = {{16{raw[15]}}, raw[15:0]};
            3'b100:  expv = {24'h0, raw[7:0]};
            3'b101:  expv = {16'h0, raw[15:0]};
            default: expv = raw;
        endcase

        memreadM   = !we;
        memwriteM  = we;
        memctrlM   = ctrl;
        aluresultM = addr;
        writedataM = data;
        #1 chk("stall_idle_req", stallM, 1);
        @(negedge clk);
        memreadM   = 1'b0;
        memwriteM  = 1'b0;
        aluresultM = 18'($urandom);
        writedataM = $urandom;
        memctrlM   = 3'($urandom);
        for (int bb = 0; bb < nbeats; bb++) begin
            wcycles = $urandom_range(0, max_wait);
            for (int w = 0; w <= wcycles; w++) begin
                chk("beat_req", mem_req, 1);
                chk("beat_addr", mem_addr, wa[bb]);
                chk("beat_be", mem_be, be[bb]);
                chk("beat_we", mem_we, we);
                chk("beat_stall", stallM, 1);
                if (we) chk("beat_wdata", mem_wdata & lane_mask(be[bb]), wexp[bb]);
                mem_ready = (w == wcycles);
                mem_rdata = (w == wcycles) ? rd[bb] : $urandom;
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk("resp_req", mem_req, 0);
        chk("resp_stall", stallM, 0);
        if (!we) last_load = expv;
        chk("resp_readdata", readdataM, last_load);
        @(negedge clk);
        chk("idle_req", mem_req, 0);
        chk("idle_stall", stallM, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_load   = 32'h0;
        rst_n       = 1'b0;
        aluresultM  = 18'h0;
        memreadM    = 1'b0;
        memwriteM   = 1'b0;
        memctrlM    = 3'b000;
        writedataM  = 32'h0;
        mem_rdata   = 32'h0;
        mem_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_readdata", readdataM, 0);
        chk("rst_stall", stallM, 0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b0, 3'b010, 18'h00100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        access(1'b0, 3'b000, 18'h00103, 32'h0, 32'h80123456, 32'h0, 0);
        access(1'b0, 3'b100, 18'h00103, 32'h0, 32'h80123456, 32'h0, 0);
        access(1'b1, 3'b001, 18'h00102, 32'h1234ABCD, 32'h0, 32'h0, 0);
        chk("store_keeps_readdata", readdataM, 32'h00000080);
        access(1'b0, 3'b010, 18'h00101, 32'h0, 32'h33221100, 32'h55667744, 0);
        chk("split_lw_value", readdataM, 32'h44332211);
        access(1'b1, 3'b010, 18'h3FFFE, 32'hAABBCCDD, 32'h0, 32'h0, 0);
        access(1'b0, 3'b001, 18'h3FFFF, 32'h0, 32'h80000000, 32'h000000FF, 1);
        chk("split_lh_wrap", readdataM, 32'hFFFFFF80);

        // Reset in the middle of a stalled BEAT0.
        memreadM   = 1'b1;
        memctrlM   = 3'b010;
        aluresultM = 18'h00200;
        @(negedge clk);
        memreadM = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_stall", stallM, 0);
        chk("rst_mid_be", mem_be, 0);
        chk("rst_mid_readdata", readdataM, 0);
        last_load = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 3'b010, 18'h00200, 32'h0, 32'hCAFEF00D, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            bit          we;
            logic [2:0]  c;
            logic [17:0] a;
            we = 1'($urandom_range(0, 1));
            if (we) begin
                c = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       c = 3'b000;
                    1:       c = 3'b001;
                    2:       c = 3'b010;
                    3:       c = 3'b100;
                    default: c = 3'b101;
                endcase
            end
            if ($urandom_range(0, 3) == 0)
                a = 18'h3FFFC + 18'($urandom_range(0, 3));
            else
                a = 18'($urandom);
            access(we, c, a, $urandom, $urandom, $urandom, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
